// File: rtl/cplx_sched_pkg.sv
// Shared types and widths for the round-robin complex-unit scheduler.
// Optional grant statistics are enabled with the CPLX_SCHED_STATS_EN macro.
package cplx_sched_pkg;

    localparam int CPLX_W = 32;
    localparam int LANE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OP_ADD  = 1'b0,
        OP_CONJ = 1'b1
    } op_t;

endpackage

// File: rtl/complex.sv
// Combinational complex unit: packed {real, imag} lanes, wrap-around arithmetic.
// op=0 adds a and b lane-wise; op=1 returns the conjugate of a.
module complex
    import cplx_sched_pkg::*;
(
    input  logic              op,
    input  logic [CPLX_W-1:0] a,
    input  logic [CPLX_W-1:0] b,
    output logic [CPLX_W-1:0] c
);

    logic [LANE_W-1:0] a_re;
    logic [LANE_W-1:0] a_im;
    logic [LANE_W-1:0] b_re;
    logic [LANE_W-1:0] b_im;

    assign a_re = a[CPLX_W-1:LANE_W];
    assign a_im = a[LANE_W-1:0];
    assign b_re = b[CPLX_W-1:LANE_W];
    assign b_im = b[LANE_W-1:0];

    // Negating 0x8000 wraps back to 0x8000, matching two's complement hardware.
    always_comb begin
        c = '0;
        if (op_t'(op) == OP_CONJ) begin
            c = {a_re, LANE_W'(16'h0000 - a_im)};
        end else begin
            c = {LANE_W'(a_re + b_re), LANE_W'(a_im + b_im)};
        end
    end

endmodule

// File: rtl/cplx_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr,
// wrapping modulo NUM_REQ. Outputs a one-hot grant, its index and an any flag.
module cplx_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PW      = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PW-1:0]      grant_idx,
    output logic               any
);

    logic [PW-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = PW'((int'(ptr) + k) % NUM_REQ);
            if (!any && valid[idx]) begin
                any        = 1'b1;
                grant_idx  = idx;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cplx_rr_sched.sv
// Round-robin scheduler sharing one complex unit between NUM_REQ requesters.
// Define CPLX_SCHED_STATS_EN to add saturating per-requester grant counters (grant_cnt).
module cplx_rr_sched
    import cplx_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_op,
    input  logic [NUM_REQ*CPLX_W-1:0] req_a,
    input  logic [NUM_REQ*CPLX_W-1:0] req_b,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [CPLX_W-1:0]         rsp_data,
    output logic                      busy
`ifdef CPLX_SCHED_STATS_EN
    ,
    output logic [NUM_REQ*CNT_W-1:0]  grant_cnt
`endif
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 1 || NUM_REQ > 8) begin : g_bad_num_req
        $error("cplx_rr_sched: NUM_REQ must be in 1..8");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("cplx_rr_sched: CNT_W must be at least 1");
    end

    // Valid/ready: a request transfers in a cycle where req_valid[i] and
    // req_ready[i] are both high; a response transfers when rsp_valid[owner]
    // and rsp_ready[owner] are both high. Ready is only offered in IDLE.

    state_t            state;
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     owner;
    op_t               op_q;
    logic [CPLX_W-1:0] a_q;
    logic [CPLX_W-1:0] b_q;
    logic [CPLX_W-1:0] c;

    logic [NUM_REQ-1:0] grant;
    logic [PW-1:0]      grant_idx;
    logic               grant_any;
    logic [PW-1:0]      next_ptr;

    logic [CPLX_W-1:0] a_arr [NUM_REQ];
    logic [CPLX_W-1:0] b_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*CPLX_W +: CPLX_W];
        assign b_arr[i] = req_b[i*CPLX_W +: CPLX_W];
    end

    cplx_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_pick (
        .valid     (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    complex u_complex (
        .op (op_q),
        .a  (a_q),
        .b  (b_q),
        .c  (c)
    );

    // Ready follows valid in the same cycle; gated by rst so it reads 0 during reset.
    assign req_ready = (state == IDLE && !rst) ? grant : '0;
    assign next_ptr  = (grant_idx == PW'(NUM_REQ - 1)) ? '0 : PW'(grant_idx + 1'b1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            op_q      <= OP_ADD;
            a_q       <= '0;
            b_q       <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        op_q   <= op_t'(req_op[grant_idx]);
                        a_q    <= a_arr[grant_idx];
                        b_q    <= b_arr[grant_idx];
                        owner  <= grant_idx;
                        rr_ptr <= next_ptr;
                        busy   <= 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= c;
                    rsp_valid <= NUM_REQ'(1) << owner;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready[owner]) begin
                        rsp_valid <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= '0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef CPLX_SCHED_STATS_EN
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stats
        logic [CNT_W-1:0] cnt;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
            end else if (req_ready[i] && req_valid[i] && cnt != {CNT_W{1'b1}}) begin
                cnt <= cnt + 1'b1;
            end
        end
        assign grant_cnt[i*CNT_W +: CNT_W] = cnt;
    end
`endif

endmodule
